// File: rtl/naneye_pixel_deser.sv
// NanEye pixel deserializer: assembles start/data/stop framed sensor words
// from the decoded bit stream into pixels and tracks column/row position.
module naneye_pixel_deser #(
  parameter int G_PIX_W     = 10,
  parameter int G_COLS      = 250,
  parameter int G_ROWS      = 250,
  parameter int G_CNT_W     = 8,
  parameter int G_ERR_CNT_W = 8
) (
  input  logic                   SCLOCK,
  input  logic                   RESET,
  input  logic                   ENABLE,
  input  logic                   FRAME_START,
  input  logic                   DATA_IN,
  input  logic                   DATA_EN,
  output logic [G_PIX_W-1:0]     PIXEL_DATA,
  output logic                   PIXEL_VALID,
  output logic [G_CNT_W-1:0]     COL,
  output logic [G_CNT_W-1:0]     ROW,
  output logic                   LINE_END,
  output logic                   FRAME_END,
  output logic                   ERROR_OUT,
  output logic [G_ERR_CNT_W-1:0] ERR_CNT
);

  localparam int BIT_W = (G_PIX_W > 1) ? $clog2(G_PIX_W) : 1;
  localparam logic [BIT_W-1:0]   LAST_BIT = BIT_W'(G_PIX_W - 1);
  localparam logic [G_CNT_W-1:0] LAST_COL = G_CNT_W'(G_COLS - 1);
  localparam logic [G_CNT_W-1:0] LAST_ROW = G_CNT_W'(G_ROWS - 1);

  typedef enum logic [1:0] {IDLE, HUNT, DATA, STOP} state_t;

  state_t                 state_q, state_d;
  logic [G_PIX_W-1:0]     shift_q, shift_d;
  logic [BIT_W-1:0]       bit_cnt_q, bit_cnt_d;
  // Position of the next pixel to be reported (internal, cleared per frame)
  logic [G_CNT_W-1:0]     col_q, col_d;
  logic [G_CNT_W-1:0]     row_q, row_d;
  // Registered outputs
  logic [G_PIX_W-1:0]     pix_data_q, pix_data_d;
  logic [G_CNT_W-1:0]     pix_col_q, pix_col_d;
  logic [G_CNT_W-1:0]     pix_row_q, pix_row_d;
  logic                   pix_valid_q, pix_valid_d;
  logic                   line_end_q, line_end_d;
  logic                   frame_end_q, frame_end_d;
  logic                   error_q, error_d;
  logic [G_ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic                   err_event;

  // Next-state / next-output computation; restart takes priority over bits
  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    bit_cnt_d   = bit_cnt_q;
    col_d       = col_q;
    row_d       = row_q;
    pix_data_d  = pix_data_q;
    pix_col_d   = pix_col_q;
    pix_row_d   = pix_row_q;
    err_cnt_d   = err_cnt_q;
    pix_valid_d = 1'b0;
    line_end_d  = 1'b0;
    frame_end_d = 1'b0;
    err_event   = 1'b0;

    if (!ENABLE) begin
      // Disabled: drop any partial word silently, hold position and outputs
      state_d   = IDLE;
      bit_cnt_d = '0;
      shift_d   = '0;
    end else if (FRAME_START && state_q != IDLE) begin
      // Restart is only harmless when sitting in HUNT at the frame origin
      if (state_q != HUNT || col_q != '0 || row_q != '0) begin
        err_event = 1'b1;
      end
      state_d   = HUNT;
      col_d     = '0;
      row_d     = '0;
      bit_cnt_d = '0;
      shift_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (FRAME_START) begin
            state_d = HUNT;
            col_d   = '0;
            row_d   = '0;
          end
        end
        HUNT: begin
          if (DATA_EN && DATA_IN) begin
            state_d   = DATA;
            bit_cnt_d = '0;
          end
        end
        DATA: begin
          if (DATA_EN) begin
            shift_d = {shift_q[G_PIX_W-2:0], DATA_IN};
            if (bit_cnt_q == LAST_BIT) begin
              state_d = STOP;
            end else begin
              bit_cnt_d = bit_cnt_q + BIT_W'(1);
            end
          end
        end
        STOP: begin
          if (DATA_EN) begin
            state_d = HUNT;
            if (!DATA_IN) begin
              pix_valid_d = 1'b1;
              pix_data_d  = shift_q;
              pix_col_d   = col_q;
              pix_row_d   = row_q;
              if (col_q == LAST_COL) begin
                line_end_d = 1'b1;
                col_d      = '0;
                if (row_q == LAST_ROW) begin
                  frame_end_d = 1'b1;
                  row_d       = '0;
                  state_d     = IDLE;
                end else begin
                  row_d = row_q + G_CNT_W'(1);
                end
              end else begin
                col_d = col_q + G_CNT_W'(1);
              end
            end else begin
              // Bad stop bit: discard word, position stays put
              err_event = 1'b1;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end

    error_d = err_event;
    if (err_event && err_cnt_q != '1) begin
      err_cnt_d = err_cnt_q + G_ERR_CNT_W'(1);
    end
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge SCLOCK) begin
    if (!RESET) begin
      state_q     <= IDLE;
      shift_q     <= '0;
      bit_cnt_q   <= '0;
      col_q       <= '0;
      row_q       <= '0;
      pix_data_q  <= '0;
      pix_col_q   <= '0;
      pix_row_q   <= '0;
      pix_valid_q <= 1'b0;
      line_end_q  <= 1'b0;
      frame_end_q <= 1'b0;
      error_q     <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      bit_cnt_q   <= bit_cnt_d;
      col_q       <= col_d;
      row_q       <= row_d;
      pix_data_q  <= pix_data_d;
      pix_col_q   <= pix_col_d;
      pix_row_q   <= pix_row_d;
      pix_valid_q <= pix_valid_d;
      line_end_q  <= line_end_d;
      frame_end_q <= frame_end_d;
      error_q     <= error_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign PIXEL_DATA  = pix_data_q;
  assign PIXEL_VALID = pix_valid_q;
  assign COL         = pix_col_q;
  assign ROW         = pix_row_q;
  assign LINE_END    = line_end_q;
  assign FRAME_END   = frame_end_q;
  assign ERROR_OUT   = error_q;
  assign ERR_CNT     = err_cnt_q;

endmodule

// File: tb/tb_naneye_pixel_deser.sv
// Randomized self-checking bench for naneye_pixel_deser using a
// word-level reference model (frame membership, position, error count).
module tb_naneye_pixel_deser;

  localparam int PIX_W = 10;
  localparam int COLS  = 16;
  localparam int ROWS  = 4;
  localparam int CNT_W = 8;
  localparam int ERR_W = 8;
  localparam int ERR_MAX = (1 << ERR_W) - 1;

  logic             SCLOCK = 1'b0;
  logic             RESET = 1'b0;
  logic             ENABLE = 1'b0;
  logic             FRAME_START = 1'b0;
  logic             DATA_IN = 1'b0;
  logic             DATA_EN = 1'b0;
  logic [PIX_W-1:0] PIXEL_DATA;
  logic             PIXEL_VALID;
  logic [CNT_W-1:0] COL;
  logic [CNT_W-1:0] ROW;
  logic             LINE_END;
  logic             FRAME_END;
  logic             ERROR_OUT;
  logic [ERR_W-1:0] ERR_CNT;

  naneye_pixel_deser #(
    .G_PIX_W(PIX_W), .G_COLS(COLS), .G_ROWS(ROWS),
    .G_CNT_W(CNT_W), .G_ERR_CNT_W(ERR_W)
  ) dut (
    .SCLOCK(SCLOCK), .RESET(RESET), .ENABLE(ENABLE),
    .FRAME_START(FRAME_START), .DATA_IN(DATA_IN), .DATA_EN(DATA_EN),
    .PIXEL_DATA(PIXEL_DATA), .PIXEL_VALID(PIXEL_VALID),
    .COL(COL), .ROW(ROW), .LINE_END(LINE_END), .FRAME_END(FRAME_END),
    .ERROR_OUT(ERROR_OUT), .ERR_CNT(ERR_CNT)
  );

  always #5 SCLOCK = ~SCLOCK;

  int n_checks = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: word-level view of the frame
  bit m_in_frame = 1'b0;
  int m_col = 0, m_row = 0, m_err_total = 0;
  int m_hold_data = 0, m_hold_col = 0, m_hold_row = 0;
  int exp_pv = 0, exp_le = 0, exp_fe = 0, exp_err = 0;

  function automatic int exp_err_cnt();
    return (m_err_total > ERR_MAX) ? ERR_MAX : m_err_total;
  endfunction

  // Pulse monitor: totals and multi-cycle strobe detection
  int mon_pv = 0, mon_le = 0, mon_fe = 0, mon_err = 0, mon_double = 0;
  logic p_pv = 0, p_le = 0, p_fe = 0, p_err = 0;
  always @(negedge SCLOCK) begin
    if (PIXEL_VALID === 1'b1) mon_pv++;
    if (LINE_END === 1'b1) mon_le++;
    if (FRAME_END === 1'b1) mon_fe++;
    if (ERROR_OUT === 1'b1) mon_err++;
    if ((PIXEL_VALID && p_pv) || (LINE_END && p_le) ||
        (FRAME_END && p_fe) || (ERROR_OUT && p_err)) mon_double++;
    p_pv = PIXEL_VALID; p_le = LINE_END; p_fe = FRAME_END; p_err = ERROR_OUT;
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge SCLOCK); #1;
    end
  endtask

  task automatic gap();
    idle(int'($urandom_range(0, 2)));
  endtask

  // One strobed bit; returns one step after the sampling edge
  task automatic send_bit(input logic b);
    DATA_EN = 1'b1;
    DATA_IN = b;
    @(posedge SCLOCK); #1;
    DATA_EN = 1'b0;
    DATA_IN = 1'($urandom_range(0, 1));
  endtask

  task automatic send_partial(input int n);
    send_bit(1'b1);
    for (int i = 0; i < n; i++) begin
      gap();
      send_bit(1'($urandom_range(0, 1)));
    end
    gap();
  endtask

  task automatic send_word(input logic [PIX_W-1:0] d, input logic stop);
    logic c_pv, c_err, c_le, c_fe;
    logic [PIX_W-1:0] c_data;
    logic [CNT_W-1:0] c_col, c_row;
    logic [ERR_W-1:0] c_cnt;
    bit e_pv, e_err, e_le, e_fe;
    send_bit(1'b1);
    for (int i = PIX_W - 1; i >= 0; i--) begin
      gap();
      send_bit(d[i]);
    end
    gap();
    send_bit(stop);
    c_pv = PIXEL_VALID; c_err = ERROR_OUT; c_le = LINE_END; c_fe = FRAME_END;
    c_data = PIXEL_DATA; c_col = COL; c_row = ROW; c_cnt = ERR_CNT;
    e_pv = 0; e_err = 0; e_le = 0; e_fe = 0;
    if (m_in_frame && !stop) begin
      e_pv = 1;
      e_le = (m_col == COLS - 1);
      e_fe = e_le && (m_row == ROWS - 1);
      m_hold_data = int'(d); m_hold_col = m_col; m_hold_row = m_row;
      exp_pv++;
      if (e_le) exp_le++;
      if (e_fe) exp_fe++;
      m_col++;
      if (m_col == COLS) begin
        m_col = 0;
        m_row++;
        if (m_row == ROWS) begin
          m_row = 0;
          m_in_frame = 0;
        end
      end
    end else if (m_in_frame && stop) begin
      e_err = 1;
      m_err_total++;
      exp_err++;
    end
    chk("word_pv", c_pv, e_pv);
    chk("word_err", c_err, e_err);
    chk("word_data", c_data, m_hold_data);
    chk("word_col", c_col, m_hold_col);
    chk("word_row", c_row, m_hold_row);
    chk("word_line_end", c_le, e_le);
    chk("word_frame_end", c_fe, e_fe);
    chk("word_err_cnt", c_cnt, exp_err_cnt());
    $display("word d=%03h stop=%0b pv=%0b col=%0d row=%0d le=%0b fe=%0b err=%0b errcnt=%0d",
             d, stop, c_pv, c_col, c_row, c_le, c_fe, c_err, c_cnt);
    gap();
  endtask

  // FRAME_START pulse, optionally with a coincident bit strobe
  task automatic pulse_fs(input bit mid_word, input logic with_bit, input logic bitval);
    logic c_err, c_pv;
    bit e_err;
    FRAME_START = 1'b1;
    DATA_EN = with_bit;
    DATA_IN = bitval;
    @(posedge SCLOCK); #1;
    FRAME_START = 1'b0;
    DATA_EN = 1'b0;
    c_err = ERROR_OUT; c_pv = PIXEL_VALID;
    e_err = m_in_frame && (mid_word || m_col != 0 || m_row != 0);
    if (e_err) begin
      m_err_total++;
      exp_err++;
    end
    m_in_frame = 1; m_col = 0; m_row = 0;
    chk("fs_err", c_err, e_err);
    chk("fs_pv", c_pv, 1'b0);
    chk("fs_err_cnt", ERR_CNT, exp_err_cnt());
    $display("frame_start mid=%0b err=%0b errcnt=%0d", mid_word, c_err, ERR_CNT);
    gap();
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_data"}, PIXEL_DATA, 0);
    chk({tag, "_pv"}, PIXEL_VALID, 0);
    chk({tag, "_col"}, COL, 0);
    chk({tag, "_row"}, ROW, 0);
    chk({tag, "_le"}, LINE_END, 0);
    chk({tag, "_fe"}, FRAME_END, 0);
    chk({tag, "_err"}, ERROR_OUT, 0);
    chk({tag, "_err_cnt"}, ERR_CNT, 0);
  endtask

  initial begin
    // Reset state
    RESET = 1'b0;
    ENABLE = 1'b1;
    idle(3);
    chk_reset_outputs("reset");
    RESET = 1'b1;
    idle(2);

    // First word after frame start
    pulse_fs(0, 0, 0);
    send_word(10'h2A5, 1'b0);

    // Stop-bit error, then next word reported at the same column
    send_word(PIX_W'($urandom), 1'b0);
    send_word(PIX_W'($urandom), 1'b1);
    send_word(PIX_W'($urandom), 1'b0);

    // Restart at a word boundary away from the origin aborts the frame
    pulse_fs(0, 0, 0);

    // Full frame with incrementing pattern, then words while idle
    for (int k = 0; k < COLS * ROWS; k++) send_word(PIX_W'(k), 1'b0);
    chk("frame_done_idle", m_in_frame, 0);
    for (int k = 0; k < 3; k++) send_word(PIX_W'($urandom), 1'b0);

    // Mid-word restart at column 10 with a coincident start-like bit
    pulse_fs(0, 0, 0);
    while (m_col != 10) send_word(PIX_W'($urandom), 1'b0);
    send_partial(5);
    pulse_fs(1, 1, 1);
    send_word(10'h155, 1'b0);
    chk("restart_col", COL, 0);
    chk("restart_row", ROW, 0);

    // Error counter saturation
    for (int k = 0; k < 300; k++) send_word(PIX_W'($urandom), 1'b1);
    chk("sat_err_cnt", ERR_CNT, ERR_MAX);

    // ENABLE low mid-word: no strobes, held outputs, back to idle
    send_word(PIX_W'($urandom), 1'b0);
    send_partial(3);
    ENABLE = 1'b0;
    send_bit(1'b0);
    send_bit(1'b1);
    chk("dis_pv", PIXEL_VALID, 0);
    chk("dis_err", ERROR_OUT, 0);
    chk("dis_data", PIXEL_DATA, m_hold_data);
    chk("dis_col", COL, m_hold_col);
    chk("dis_row", ROW, m_hold_row);
    chk("dis_err_cnt", ERR_CNT, exp_err_cnt());
    ENABLE = 1'b1;
    m_in_frame = 0;
    idle(1);
    send_word(PIX_W'($urandom), 1'b0);
    pulse_fs(0, 0, 0);
    send_word(PIX_W'($urandom), 1'b0);
    send_word(PIX_W'($urandom), 1'b1);

    // Reset mid-word: outputs clear on the next edge without an error pulse
    send_partial(4);
    RESET = 1'b0;
    idle(1);
    chk_reset_outputs("midreset");
    RESET = 1'b1;
    m_in_frame = 0; m_col = 0; m_row = 0; m_err_total = 0;
    m_hold_data = 0; m_hold_col = 0; m_hold_row = 0;
    idle(1);
    pulse_fs(0, 0, 0);
    send_word(PIX_W'($urandom), 1'b0);
    send_word(PIX_W'($urandom), 1'b0);

    // Pulse totals across the whole run
    idle(3);
    chk("total_pv", mon_pv, exp_pv);
    chk("total_le", mon_le, exp_le);
    chk("total_fe", mon_fe, exp_fe);
    chk("total_err", mon_err, exp_err);
    chk("strobe_width", mon_double, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
